// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared state/direction encodings for the snake controller
//
// Purpose : FSM state encoding, move-direction encoding (DIR_UP/DOWN/LEFT/RIGHT)
//           and a reversal helper used by the controller.
// Ports   : none (package)
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READY = 2'b01,
    ST_RUN   = 2'b10,
    ST_DEAD  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  // Opposite directions share the axis bit (bit 1) and differ in bit 0.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_ctrl_if.sv
// rtl/snake_ctrl_if.sv - step handshake between the controller and the body datapath
//
// Purpose : groups the step request/acknowledge bus.
// Signals : O_step_req  controller -> datapath, request one move
//           O_dir       controller -> datapath, move direction (stable while requesting)
//           O_clear     controller -> datapath, one-cycle reinitialise pulse
//           I_step_ack  datapath -> controller, move done
//           I_collide   datapath -> controller, collision (valid with I_step_ack)
//           I_eaten     datapath -> controller, food eaten (valid with I_step_ack)
import snake_pkg::*;

interface snake_ctrl_if;
  logic O_step_req;
  dir_t O_dir;
  logic O_clear;
  logic I_step_ack;
  logic I_collide;
  logic I_eaten;

  modport master (
    output O_step_req, O_dir, O_clear,
    input  I_step_ack, I_collide, I_eaten
  );

  modport slave (
    input  O_step_req, O_dir, O_clear,
    output I_step_ack, I_collide, I_eaten
  );
endinterface

// File: rtl/snake_btn_sync.sv
// rtl/snake_btn_sync.sv - button synchronisers and direction priority encoder
//
// Purpose : brings the four raw direction buttons into the I_clk domain through
//           two flops each and picks one direction, up > down > left > right.
// Ports   : I_clk, I_rst_n                   clock, async active-low reset
//           I_button_u/d/l/r                 raw asynchronous buttons, active-high
//           O_valid                          some synchronised button is pressed
//           O_dir                            highest-priority pressed direction
import snake_pkg::*;

module snake_btn_sync (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_button_u,
  input  logic I_button_d,
  input  logic I_button_l,
  input  logic I_button_r,
  output logic O_valid,
  output dir_t O_dir
);

  // Bit order {u, d, l, r}
  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= {I_button_u, I_button_d, I_button_l, I_button_r};
      r_sync <= r_meta;
    end
  end

  always_comb begin
    O_valid = |r_sync;
    O_dir   = DIR_RIGHT;
    if (r_sync[3])      O_dir = DIR_UP;
    else if (r_sync[2]) O_dir = DIR_DOWN;
    else if (r_sync[1]) O_dir = DIR_LEFT;
  end

endmodule

// File: rtl/snake_ctrl.sv
// rtl/snake_ctrl.sv - snake game controller: game FSM, move timer, direction and score
//
// Purpose : sequences IDLE/READY/RUN/DEAD, issues one step request per move
//           period, tracks the steering direction and counts food eaten.
// Ports   : I_clk, I_rst_n        clock, async active-low reset
//           I_load, I_drive       reload-game / start-run requests (level)
//           I_button_u/d/l/r      raw direction buttons
//           bus (master)          step handshake with the body datapath
//           O_state               FSM state
//           O_score               food eaten this game, saturating
import snake_pkg::*;

module snake_ctrl #(
  parameter int TICK_DIV = 25_000_000,
  parameter int SCORE_W  = 8
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_load,
  input  logic               I_drive,
  input  logic               I_button_u,
  input  logic               I_button_d,
  input  logic               I_button_l,
  input  logic               I_button_r,
  snake_ctrl_if.master       bus,
  output logic [1:0]         O_state,
  output logic [SCORE_W-1:0] O_score
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [TICK_W-1:0]   r_tick;
  logic                r_step_req;
  logic                r_clear;
  dir_t                r_dir;   // last issued direction
  dir_t                r_pend;  // direction for the next step
  logic [SCORE_W-1:0]  r_score;

  logic                w_btn_valid;
  dir_t                w_btn_dir;
  logic                w_run;
  logic                w_wrap;
  logic                w_ack_ok;

  snake_btn_sync u_btn_sync (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_button_u (I_button_u),
    .I_button_d (I_button_d),
    .I_button_l (I_button_l),
    .I_button_r (I_button_r),
    .O_valid    (w_btn_valid),
    .O_dir      (w_btn_dir)
  );

  // State register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next state; load overrides everything else in the same cycle
  always_comb begin
    w_state_next = r_state;
    if (I_load) begin
      w_state_next = ST_READY;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_IDLE;
        ST_READY: if (I_drive) w_state_next = ST_RUN;
        ST_RUN:   if (w_ack_ok && bus.I_collide) w_state_next = ST_DEAD;
        ST_DEAD:  w_state_next = ST_DEAD;
      endcase
    end
  end

  // Outputs and state decodes
  always_comb begin
    w_run          = (r_state == ST_RUN);
    w_wrap         = w_run && (r_tick == TICK_LAST);
    // An ack only counts while a request is outstanding
    w_ack_ok       = w_run && r_step_req && bus.I_step_ack;
    O_state        = r_state;
    O_score        = r_score;
    bus.O_step_req = r_step_req;
    bus.O_dir      = r_dir;
    bus.O_clear    = r_clear;
  end

  // Move timer, step handshake, steering and score
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_tick     <= '0;
      r_step_req <= 1'b0;
      r_clear    <= 1'b0;
      r_dir      <= DIR_RIGHT;
      r_pend     <= DIR_RIGHT;
      r_score    <= '0;
    end else begin
      r_clear <= 1'b0;
      if (I_load) begin
        r_clear    <= 1'b1;
        r_tick     <= '0;
        r_step_req <= 1'b0;
        r_dir      <= DIR_RIGHT;
        r_pend     <= DIR_RIGHT;
        r_score    <= '0;
      end else begin
        if (w_run && (w_state_next == ST_RUN))
          r_tick <= w_wrap ? '0 : r_tick + 1'b1;
        else
          r_tick <= '0;

        // A wrap while a request is still open is dropped, not queued
        if (w_ack_ok) begin
          r_step_req <= 1'b0;
          if (!bus.I_collide && bus.I_eaten && (r_score != '1))
            r_score <= r_score + 1'b1;
        end else if (w_wrap && !r_step_req) begin
          r_step_req <= 1'b1;
          r_dir      <= r_pend;
        end

        // Steering is frozen while a step is in flight; reversals are refused
        if (w_run && !r_step_req && w_btn_valid && !is_reverse(w_btn_dir, r_dir))
          r_pend <= w_btn_dir;
      end
    end
  end

endmodule

// File: tb/tb_snake_ctrl.sv
// tb/tb_snake_ctrl.sv - self-checking bench for snake_ctrl (TICK_DIV=4, SCORE_W=8)
module tb_snake_ctrl;
  import snake_pkg::*;

  typedef struct {
    int ld; int dr; int ak; int co; int ea;
    int st; int rq; int cl; int sc; int di;
  } vec_t;

  typedef struct { int dir; int gap; } step_t;
  typedef struct { bit eat; bit col; } resp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic       drive = 1'b0;
  logic       bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
  logic [1:0] state;
  logic [7:0] score;

  snake_ctrl_if bus();

  snake_ctrl #(.TICK_DIV(4), .SCORE_W(8)) dut (
    .I_clk      (clk),
    .I_rst_n    (rst_n),
    .I_load     (load),
    .I_drive    (drive),
    .I_button_u (bu),
    .I_button_d (bd),
    .I_button_l (bl),
    .I_button_r (br),
    .bus        (bus),
    .O_state    (state),
    .O_score    (score)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    last_rise = 0;
  int    rise_cnt = 0;
  int    clr_cnt = 0;
  int    req_age = 0;
  int    ack_delay = 0;
  int    exp_dir_now = 3;
  bit    auto_ack = 0;
  bit    sb_en = 0;
  bit    prev_req = 0;
  step_t exp_q[$];
  resp_t resp_q[$];
  vec_t  tbl[28];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_step(input int dir, input int gap, input int n);
    step_t e;
    e.dir = dir;
    e.gap = gap;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic push_resp(input bit eat, input bit col, input int n);
    resp_t r;
    r.eat = eat;
    r.col = col;
    for (int i = 0; i < n; i++) resp_q.push_back(r);
  endtask

  // One clock: sample 1 time unit after the edge, score step rises, drive the responder
  task automatic clk_step();
    step_t e;
    resp_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.O_clear) clr_cnt++;
    if (bus.O_step_req && !prev_req) begin
      rise_cnt++;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected step: got dir %0d at cycle %0d, expected no step", int'(bus.O_dir), cyc);
        end else begin
          e = exp_q.pop_front();
          exp_dir_now = e.dir;
          check("step dir", int'(bus.O_dir), e.dir);
          check("step gap", cyc - last_rise, e.gap);
        end
      end
      last_rise = cyc;
    end else if (bus.O_step_req && prev_req && sb_en) begin
      check("held dir", int'(bus.O_dir), exp_dir_now);
    end
    prev_req = bus.O_step_req;
    if (auto_ack) begin
      if (bus.O_step_req) begin
        if (req_age >= ack_delay) begin
          bus.I_step_ack = 1'b1;
          if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            bus.I_eaten   = r.eat;
            bus.I_collide = r.col;
          end else begin
            bus.I_eaten   = 1'b0;
            bus.I_collide = 1'b0;
          end
        end else begin
          bus.I_step_ack = 1'b0;
          bus.I_eaten    = 1'b0;
          bus.I_collide  = 1'b0;
        end
        req_age++;
      end else begin
        bus.I_step_ack = 1'b0;
        bus.I_eaten    = 1'b0;
        bus.I_collide  = 1'b0;
        req_age        = 0;
      end
    end
  endtask

  initial begin
    int c;
    int c0;
    int rc;
    bus.I_step_ack = 1'b0;
    bus.I_collide  = 1'b0;
    bus.I_eaten    = 1'b0;

    //              ld dr ak co ea   st rq cl sc di
    tbl[0]  = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 3};  // drive ignored in IDLE
    tbl[1]  = '{0, 0, 1, 1, 1,  0, 0, 0, 0, 3};  // ack ignored in IDLE
    tbl[2]  = '{1, 0, 0, 0, 0,  1, 0, 1, 0, 3};  // load -> READY, clear
    tbl[3]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 3};
    tbl[4]  = '{0, 0, 1, 0, 1,  1, 0, 0, 0, 3};  // ack in READY ignored
    tbl[5]  = '{0, 1, 0, 0, 0,  2, 0, 0, 0, 3};  // drive -> RUN, tick 0
    tbl[6]  = '{0, 0, 0, 0, 0,  2, 0, 0, 0, 3};
    tbl[7]  = '{0, 0, 0, 0, 0,  2, 0, 0, 0, 3};
    tbl[8]  = '{0, 0, 0, 0, 0,  2, 0, 0, 0, 3};
    tbl[9]  = '{0, 0, 0, 0, 0,  2, 1, 0, 0, 3};  // first request
    tbl[10] = '{0, 0, 1, 0, 1,  2, 0, 0, 1, 3};  // ack + eaten
    tbl[11] = '{0, 0, 0, 0, 0,  2, 0, 0, 1, 3};
    tbl[12] = '{0, 0, 0, 0, 0,  2, 0, 0, 1, 3};
    tbl[13] = '{0, 0, 0, 0, 0,  2, 1, 0, 1, 3};
    tbl[14] = '{0, 0, 1, 0, 0,  2, 0, 0, 1, 3};  // ack, nothing eaten
    tbl[15] = '{0, 0, 0, 0, 0,  2, 0, 0, 1, 3};
    tbl[16] = '{0, 0, 0, 0, 0,  2, 0, 0, 1, 3};
    tbl[17] = '{0, 0, 0, 0, 0,  2, 1, 0, 1, 3};
    tbl[18] = '{0, 0, 0, 0, 0,  2, 1, 0, 1, 3};  // request held without ack
    tbl[19] = '{0, 0, 1, 1, 1,  3, 0, 0, 1, 3};  // collide wins over eaten
    tbl[20] = '{0, 1, 0, 0, 0,  3, 0, 0, 1, 3};
    tbl[21] = '{0, 0, 1, 0, 1,  3, 0, 0, 1, 3};
    tbl[22] = '{0, 0, 0, 0, 0,  3, 0, 0, 1, 3};
    tbl[23] = '{0, 0, 0, 0, 0,  3, 0, 0, 1, 3};
    tbl[24] = '{0, 0, 0, 0, 0,  3, 0, 0, 1, 3};
    tbl[25] = '{0, 0, 0, 0, 0,  3, 0, 0, 1, 3};
    tbl[26] = '{1, 1, 0, 0, 0,  1, 0, 1, 0, 3};  // load beats drive
    tbl[27] = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 3};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset state", int'(state), 0);
    check("reset req", int'(bus.O_step_req), 0);
    check("reset clear", int'(bus.O_clear), 0);
    check("reset dir", int'(bus.O_dir), 3);
    check("reset score", int'(score), 0);
    rst_n = 1'b1;

    // Table-driven control vectors
    for (int i = 0; i < 28; i++) begin
      load           = (tbl[i].ld != 0);
      drive          = (tbl[i].dr != 0);
      bus.I_step_ack = (tbl[i].ak != 0);
      bus.I_collide  = (tbl[i].co != 0);
      bus.I_eaten    = (tbl[i].ea != 0);
      clk_step();
      check($sformatf("row%0d state", i), int'(state), tbl[i].st);
      check($sformatf("row%0d req", i), int'(bus.O_step_req), tbl[i].rq);
      check($sformatf("row%0d clear", i), int'(bus.O_clear), tbl[i].cl);
      check($sformatf("row%0d score", i), int'(score), tbl[i].sc);
      check($sformatf("row%0d dir", i), int'(bus.O_dir), tbl[i].di);
    end
    load = 0; drive = 0;
    bus.I_step_ack = 0; bus.I_collide = 0; bus.I_eaten = 0;

    // Steering, held ack, eating and death with the scoreboard
    c = clr_cnt;
    load = 1; clk_step(); load = 0;
    check("B load state", int'(state), 1);
    clk_step(); clk_step();
    check("B clear pulses", clr_cnt - c, 1);
    auto_ack = 1; ack_delay = 0; sb_en = 1;
    push_step(3, 4, 5);
    push_step(0, 4, 1);
    drive = 1; clk_step(); drive = 0;
    last_rise = cyc; c0 = cyc;
    repeat (13) clk_step();
    bl = 1; clk_step(); bl = 0;            // reversal of right, must not stick
    repeat (6) clk_step();
    bu = 1; clk_step(); bu = 0;            // lands before the step at +24
    repeat (5) clk_step();
    ack_delay = 10;
    push_step(0, 4, 1);                    // +28, then ack withheld
    push_step(0, 12, 1);                   // +40, wraps at +32/+36 dropped
    repeat (4) clk_step();
    br = 1; clk_step(); br = 0;            // pressed while request is open
    repeat (8) clk_step();
    check("B cycle bookkeeping", cyc - c0, 39);
    ack_delay = 0;
    push_step(0, 4, 3);
    push_resp(1, 0, 3);
    push_resp(1, 1, 1);
    repeat (20) clk_step();
    check("B dead state", int'(state), 3);
    check("B dead score", int'(score), 3);
    check("B dead req", int'(bus.O_step_req), 0);
    rc = rise_cnt;
    repeat (10) clk_step();
    check("B no step after death", rise_cnt - rc, 0);
    check("B steps outstanding", exp_q.size(), 0);

    // Reload from DEAD, then load+drive over an outstanding request
    c = clr_cnt;
    load = 1; clk_step(); load = 0;
    check("C reload state", int'(state), 1);
    check("C reload dir", int'(bus.O_dir), 3);
    check("C reload score", int'(score), 0);
    clk_step();
    check("C reload clear pulses", clr_cnt - c, 1);
    push_step(3, 4, 2);
    push_resp(1, 0, 1);
    ack_delay = 0;
    drive = 1; clk_step(); drive = 0;
    last_rise = cyc;
    repeat (5) clk_step();
    ack_delay = 100;
    repeat (4) clk_step();
    check("C score before load", int'(score), 1);
    check("C req outstanding", int'(bus.O_step_req), 1);
    c = clr_cnt;
    load = 1; drive = 1; clk_step(); load = 0; drive = 0;
    check("C load+drive state", int'(state), 1);
    check("C load+drive req", int'(bus.O_step_req), 0);
    check("C load+drive clear", int'(bus.O_clear), 1);
    check("C load+drive score", int'(score), 0);
    check("C load+drive dir", int'(bus.O_dir), 3);
    clk_step();
    check("C clear one cycle", int'(bus.O_clear), 0);
    check("C stays ready", int'(state), 1);
    check("C clear pulses", clr_cnt - c, 1);

    // Score saturation
    ack_delay = 0;
    push_step(3, 4, 257);
    push_resp(1, 0, 257);
    drive = 1; clk_step(); drive = 0;
    last_rise = cyc;
    repeat (257 * 4 + 2) clk_step();
    check("D saturated score", int'(score), 255);
    check("D state", int'(state), 2);
    check("D steps outstanding", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25_000_000, SHALL set the move period in I_clk cycles (minimum 2).
REQ-002 Parameter SCORE_W, default 8, SHALL set the width of the score counter.
REQ-003 I_clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 I_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 I_load  input  1  SHALL be the (re)load-game request, level-sampled.
REQ-006 I_drive  input  1  SHALL be the start-run request, level-sampled.
REQ-007 I_button_u / I_button_d / I_button_l / I_button_r  input  1 each  SHALL be raw asynchronous direction buttons, active-high.
REQ-008 I_step_ack  input  1  SHALL be the body-datapath acknowledge of a step request.
REQ-009 I_collide  input  1  SHALL flag a collision; valid only in the I_step_ack cycle.
REQ-010 I_eaten  input  1  SHALL flag food eaten; valid only in the I_step_ack cycle.
REQ-011 O_step_req  output  1  SHALL request one snake move from the body datapath.
REQ-012 O_dir  output  2  SHALL give the move direction: 00 up, 01 down, 10 left, 11 right.
REQ-013 O_clear  output  1  SHALL be a one-cycle pulse commanding the datapath to reinitialise the snake.
REQ-014 O_state  output  2  SHALL expose the FSM state: 00 IDLE, 01 READY, 10 RUN, 11 DEAD.
REQ-015 O_score  output  SCORE_W  SHALL give the number of food items eaten in the current game.

Function
REQ-016 FSM transitions SHALL be: IDLE -I_load-> READY; READY -I_drive-> RUN; RUN -(ack with I_collide)-> DEAD; any state -I_load-> READY.
REQ-017 I_load SHALL take priority over I_drive and over any ack in the same cycle.
REQ-018 Entering READY SHALL pulse O_clear for exactly one cycle, zero O_score, set direction to right (11), clear the tick counter and drop O_step_req.
REQ-019 I_drive outside READY and DEAD-state ack/button activity SHALL be ignored; DEAD SHALL hold until I_load.
REQ-020 In RUN the tick counter SHALL count 0..TICK_DIV-1 and wrap; it SHALL hold at 0 in all other states.
REQ-021 On the wrap cycle with O_step_req low, O_step_req SHALL rise the next cycle; a wrap while O_step_req is high SHALL be dropped (no queueing).
REQ-022 O_step_req SHALL stay high until I_step_ack is sampled high, and SHALL be low the cycle after; O_dir SHALL be stable while O_step_req is high.
REQ-023 I_step_ack with O_step_req low SHALL be ignored.
REQ-024 On accepted ack without I_collide and with I_eaten, O_score SHALL increment by 1, saturating at 2^SCORE_W-1; I_collide SHALL take precedence over I_eaten.
REQ-025 Each button SHALL pass a two-flop synchroniser; a press SHALL affect pending direction 3 cycles after the input edge.
REQ-026 Simultaneous buttons SHALL resolve by fixed priority up > down > left > right.
REQ-027 A pending direction that reverses the last issued direction (180 degrees) SHALL be ignored.
REQ-028 Pending direction SHALL update only in RUN with O_step_req low; it becomes the issued direction when O_step_req rises.

Reset
REQ-029 While I_rst_n is low: state IDLE, O_step_req 0, O_clear 0, O_dir 11, O_score 0, tick counter 0, synchronisers 0.
REQ-030 Reset deassertion SHALL take effect on the next I_clk edge without a clear pulse; O_clear only on entering READY.

Structure
REQ-031 Package snake_pkg SHALL hold the state encoding, the direction encoding and the DIR_UP/DOWN/LEFT/RIGHT constants.
REQ-032 Sub-module snake_btn_sync SHALL hold the four synchronisers and the priority encoder, outputting valid + 2-bit direction.

Verification (TICK_DIV=4)
REQ-033 Reset, I_load 1 cycle -> O_state 01, single O_clear pulse, O_dir 11, O_score 0.
REQ-034 READY + I_drive, ack one cycle after each req -> O_step_req rises every 4 cycles, O_dir 11 throughout.
REQ-035 Press I_button_l while moving right, then I_button_u -> left ignored, next step issues O_dir 00.
REQ-036 Withhold ack for 10 cycles -> req held, O_dir stable, intervening ticks dropped, one step only.
REQ-037 Ack with I_eaten=1 three times, then I_collide=1 and I_eaten=1 -> O_score 3, O_state 11, no further req.
REQ-038 I_load and I_drive together during outstanding req -> O_state 01, O_step_req 0, O_clear pulse, O_score 0.
